// File: rtl/stream_denoise_window.sv
// Streaming N_SIZE x N_SIZE neighbour-count denoiser for color-masked pixels.
// Line buffers build the window; borders are masked and the frame tail is self-flushed.
module stream_denoise_window #(
   parameter int N_SIZE      = 5,
   parameter int COLORS      = 2,
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480,
   parameter int N_THRESHOLD = 5,
   localparam int SUM_WIDTH  = $clog2(N_SIZE*N_SIZE+1),
   localparam int ROW_W      = $clog2(IMG_HEIGHT),
   localparam int COL_W      = $clog2(IMG_WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sof,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [COLORS:0]      in_pixel,
   input  logic                 thr_wr,
   input  logic [SUM_WIDTH-1:0] thr_val,
   output logic                 out_valid,
   output logic [COLORS:0]      out_pixel,
   output logic [ROW_W-1:0]     out_row,
   output logic [COL_W-1:0]     out_col,
   output logic                 busy
);

   localparam int H      = N_SIZE/2;
   localparam int PW     = COLORS+1;
   localparam int TOTAL  = IMG_WIDTH*IMG_HEIGHT;
   localparam int D      = H*IMG_WIDTH + H;
   localparam int STEP_W = $clog2(TOTAL+D+1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [STEP_W-1:0]    step_q, step_d, k;
   logic [COL_W-1:0]     col_q, col_d, colk;
   logic [ROW_W-1:0]     cr_q, cr_d;
   logic [COL_W-1:0]     cc_q, cc_d;
   logic [SUM_WIDTH-1:0] thr_q, thr_d;
   logic                 out_valid_q, out_valid_d;
   logic [PW-1:0]        out_pixel_q, out_pixel_d;
   logic [ROW_W-1:0]     out_row_q, out_row_d;
   logic [COL_W-1:0]     out_col_q, out_col_d;

   logic [PW-1:0]        win_q [N_SIZE][N_SIZE];
   logic [PW-1:0]        win_d [N_SIZE][N_SIZE];
   logic [PW-1:0]        lb_q  [N_SIZE-1][IMG_WIDTH];
   logic [PW-1:0]        newcol [N_SIZE];
   logic [SUM_WIDTH-1:0] cnt [COLORS];
   logic [PW-1:0]        pix, ctr, res;
   logic                 step, restart, emit;
   int                   tr, tc;

   always_comb begin
      state_d = state_q;
      step    = 1'b0;
      restart = 1'b0;
      pix     = '0;
      k       = step_q;
      colk    = col_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && sof) begin
               step    = 1'b1;
               restart = 1'b1;
               pix     = in_pixel;
               k       = '0;
               colk    = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (in_valid) begin
               step = 1'b1;
               pix  = in_pixel;
               if (sof) begin
                  restart = 1'b1;
                  k       = '0;
                  colk    = '0;
               end
            end
         end
         FLUSH: step = 1'b1;
         default: state_d = IDLE;
      endcase
      if (step && state_q != FLUSH && k == STEP_W'(TOTAL-1)) state_d = FLUSH;
      if (step && state_q == FLUSH && k == STEP_W'(TOTAL+D-1)) state_d = IDLE;
   end

   // Window taps hold raster index center + (r-H)*W + (c-H); mask by center coords.
   always_comb begin
      tr = 0;
      tc = 0;
      newcol[N_SIZE-1] = pix;
      for (int i = 0; i < N_SIZE-1; i++) newcol[N_SIZE-2-i] = lb_q[i][colk];
      for (int r = 0; r < N_SIZE; r++)
         for (int c = 0; c < N_SIZE; c++) win_d[r][c] = win_q[r][c];
      if (step) begin
         for (int r = 0; r < N_SIZE; r++) begin
            for (int c = 0; c < N_SIZE-1; c++) win_d[r][c] = win_q[r][c+1];
            win_d[r][N_SIZE-1] = newcol[r];
         end
      end
      for (int ch = 0; ch < COLORS; ch++) cnt[ch] = '0;
      for (int r = 0; r < N_SIZE; r++) begin
         for (int c = 0; c < N_SIZE; c++) begin
            tr = int'(cr_q) + r - H;
            tc = int'(cc_q) + c - H;
            if (tr >= 0 && tr < IMG_HEIGHT && tc >= 0 && tc < IMG_WIDTH) begin
               for (int ch = 0; ch < COLORS; ch++)
                  if (win_d[r][c][COLORS] && win_d[r][c][ch])
                     cnt[ch] = cnt[ch] + SUM_WIDTH'(1);
            end
         end
      end
      ctr = win_d[H][H];
      res = '0;
      res[COLORS] = ctr[COLORS];
      for (int ch = 0; ch < COLORS; ch++)
         res[ch] = ctr[COLORS] && ctr[ch] && (cnt[ch] >= thr_q);
   end

   always_comb begin
      emit   = step && (k >= STEP_W'(D));
      step_d = step ? k + STEP_W'(1) : step_q;
      col_d  = col_q;
      if (step) col_d = (colk == COL_W'(IMG_WIDTH-1)) ? '0 : colk + COL_W'(1);
      cr_d = cr_q;
      cc_d = cc_q;
      if (restart) begin
         cr_d = '0;
         cc_d = '0;
      end else if (emit) begin
         if (cc_q == COL_W'(IMG_WIDTH-1)) begin
            cc_d = '0;
            cr_d = cr_q + ROW_W'(1);
         end else begin
            cc_d = cc_q + COL_W'(1);
         end
      end
      thr_d       = thr_wr ? thr_val : thr_q;
      out_valid_d = emit;
      out_pixel_d = emit ? res : '0;
      out_row_d   = emit ? cr_q : '0;
      out_col_d   = emit ? cc_q : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         step_q      <= '0;
         col_q       <= '0;
         cr_q        <= '0;
         cc_q        <= '0;
         thr_q       <= SUM_WIDTH'(N_THRESHOLD);
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         for (int r = 0; r < N_SIZE; r++)
            for (int c = 0; c < N_SIZE; c++) win_q[r][c] <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         col_q       <= col_d;
         cr_q        <= cr_d;
         cc_q        <= cc_d;
         thr_q       <= thr_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         for (int r = 0; r < N_SIZE; r++)
            for (int c = 0; c < N_SIZE; c++) win_q[r][c] <= win_d[r][c];
      end
   end

   // Line buffers need no reset: stale taps are always border-masked.
   always_ff @(posedge clk) begin
      if (step) begin
         lb_q[0][colk] <= pix;
         for (int i = 1; i < N_SIZE-1; i++) lb_q[i][colk] <= lb_q[i-1][colk];
      end
   end

   assign in_ready  = (state_q != FLUSH);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_pixel = out_pixel_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;

endmodule

// File: tb/tb_stream_denoise_window.sv
// Scoreboard bench for stream_denoise_window: 3x3 window on an 8x4 frame.
module tb_stream_denoise_window;

   localparam int W     = 8;
   localparam int HT    = 4;
   localparam int TOTAL = W*HT;
   localparam int D     = W + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sof = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_pixel = '0;
   logic       thr_wr = 1'b0;
   logic [3:0] thr_val = '0;
   logic       out_valid;
   logic [2:0] out_pixel;
   logic [1:0] out_row;
   logic [2:0] out_col;
   logic       busy;

   typedef struct {
      logic [2:0] pix;
      int         row;
      int         col;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   int         thr = 3;
   logic [2:0] img [HT][W];

   always #5 clk = ~clk;

   stream_denoise_window #(
      .N_SIZE(3), .COLORS(2), .IMG_WIDTH(W), .IMG_HEIGHT(HT), .N_THRESHOLD(3)
   ) dut (
      .clk(clk), .reset(reset), .sof(sof), .in_valid(in_valid),
      .in_ready(in_ready), .in_pixel(in_pixel), .thr_wr(thr_wr),
      .thr_val(thr_val), .out_valid(out_valid), .out_pixel(out_pixel),
      .out_row(out_row), .out_col(out_col), .busy(busy)
   );

   // Reference: count valid same-color pixels in the in-frame 3x3 neighbourhood.
   function automatic logic [2:0] ref_pix(int r, int c);
      int n0 = 0;
      int n1 = 0;
      logic [2:0] t;
      logic [2:0] ctr;
      logic [2:0] o;
      ctr = img[r][c];
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (r+dr >= 0 && r+dr < HT && c+dc >= 0 && c+dc < W) begin
               t = img[r+dr][c+dc];
               if (t[2] && t[0]) n0++;
               if (t[2] && t[1]) n1++;
            end
         end
      end
      o[2] = ctr[2];
      o[1] = ctr[2] && ctr[1] && (n1 >= thr);
      o[0] = ctr[2] && ctr[0] && (n0 >= thr);
      return o;
   endfunction

   task automatic push_exp(int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.row = i / W;
         e.col = i % W;
         e.pix = ref_pix(e.row, e.col);
         q.push_back(e);
      end
   endtask

   task automatic check(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got row %0d col %0d pix %b, none expected",
                     out_row, out_col, out_pixel);
         end else begin
            e = q.pop_front();
            if (out_pixel !== e.pix || int'(out_row) != e.row || int'(out_col) != e.col) begin
               errors++;
               $display("FAIL beat: got r%0d c%0d pix %b expected r%0d c%0d pix %b",
                        out_row, out_col, out_pixel, e.row, e.col, e.pix);
            end
         end
      end
   end

   task automatic send(logic [2:0] p, logic s, bit gap);
      if (gap) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_pixel = p;
      sof      = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sof      = 1'b0;
      in_pixel = '0;
   endtask

   task automatic set_thr(int v);
      thr_wr  = 1'b1;
      thr_val = 4'(v);
      @(posedge clk); #1;
      thr_wr  = 1'b0;
      thr     = v;
   endtask

   task automatic run_frame(int n, bit gap);
      int cnt = 0;
      push_exp(n >= TOTAL ? TOTAL : (n > D ? n - D : 0));
      for (int i = 0; i < n; i++) send(img[i/W][i%W], i == 0, gap && i > 0);
      if (n >= TOTAL) begin
         while (in_ready !== 1'b1 && cnt < 50) begin
            cnt++;
            @(posedge clk); #1;
         end
         check("flush_not_ready_cycles", cnt, D);
         check("busy_after_flush", int'(busy), 0);
         @(posedge clk); #1;
         @(posedge clk); #1;
         check("queue_drained", q.size(), 0);
      end
   endtask

   task automatic fill(logic [2:0] v);
      for (int r = 0; r < HT; r++)
         for (int c = 0; c < W; c++) img[r][c] = v;
   endtask

   task automatic fill_rand();
      logic [1:0] colr;
      for (int r = 0; r < HT; r++) begin
         for (int c = 0; c < W; c++) begin
            colr = 2'($urandom_range(0, 3));
            img[r][c] = {($urandom_range(0, 3) != 0), colr};
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_pixel", int'(out_pixel), 0);
      check("rst_out_row", int'(out_row), 0);
      check("rst_out_col", int'(out_col), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_in_ready", int'(in_ready), 1);

      fill(3'b100);
      img[2][3] = 3'b101;
      run_frame(TOTAL, 1'b0);

      fill(3'b100);
      for (int r = 0; r < 3; r++)
         for (int c = 3; c < 6; c++) img[r][c] = 3'b101;
      run_frame(TOTAL, 1'b0);
      set_thr(5);
      run_frame(TOTAL, 1'b0);

      set_thr(3);
      fill(3'b100);
      img[1][6] = 3'b101;
      img[1][7] = 3'b101;
      img[2][0] = 3'b101;
      img[2][1] = 3'b101;
      run_frame(TOTAL, 1'b0);

      set_thr(7);
      fill(3'b100);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) img[r][c] = 3'b101;
      img[0][0] = 3'b001;
      img[0][1] = 3'b001;
      img[2][2] = 3'b001;
      img[2][5] = 3'b011;
      run_frame(TOTAL, 1'b0);

      set_thr(3);
      fill_rand();
      run_frame(TOTAL, 1'b1);

      fill_rand();
      run_frame(20, 1'b0);
      fill_rand();
      run_frame(TOTAL, 1'b0);

      fill_rand();
      run_frame(15, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      thr   = 3;
      check("reset_mid_out_valid", int'(out_valid), 0);
      check("reset_mid_busy", int'(busy), 0);
      for (int i = 0; i < 6; i++) begin
         send(3'b111, 1'b0, 1'b0);
         check("no_beats_before_sof", int'(out_valid), 0);
      end
      check("reset_queue_empty", q.size(), 0);
      fill_rand();
      run_frame(TOTAL, 1'b0);

      set_thr(0);
      fill_rand();
      run_frame(TOTAL, 1'b1);
      for (int f = 0; f < 3; f++) begin
         set_thr($urandom_range(1, 9));
         fill_rand();
         run_frame(TOTAL, f[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
